// File: rtl/maze_pkt_ingress_pkg.sv
// maze_ingress_pkg: shared types and helpers for the MAZE packet ingress block.
//   pkt_entry_t : FIFO entry {type, src, tgt, data} at the default field widths
//   rr_pick     : round-robin selector over up to eight requesters
package maze_ingress_pkg;

  parameter int PKT_TYPE_W = 2;
  parameter int PKT_ID_W   = 6;
  parameter int PKT_FLIT_W = 8;
  localparam int MAX_CH    = 8;

  typedef struct packed {
    logic [PKT_TYPE_W-1:0] ptype;
    logic [PKT_ID_W-1:0]   src;
    logic [PKT_ID_W-1:0]   tgt;
    logic [PKT_FLIT_W-1:0] data;
  } pkt_entry_t;

  // First set bit of req at or after ptr, wrapping. Unused upper request bits
  // must be zero, so an 8-wide wrap behaves like a wrap at the channel count.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr);
    logic [2:0] idx;
    rr_pick = ptr;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      idx = ptr + 3'(k);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/maze_pkt_ingress_if.sv
// maze_pkt_ingress_if: packed multi-channel packet input bus plus the merged
// output stream of the ingress block.
//   master : packet sources / downstream sink (drives in_*, out_rdy)
//   slave  : the ingress block (drives in_rdy, out_*)
interface maze_pkt_ingress_if #(
  parameter int NUM_CH = 2,
  parameter int TYPE_W = 2,
  parameter int ID_W   = 6,
  parameter int FLIT_W = 8,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
  logic [NUM_CH-1:0]        in_vld;
  logic [NUM_CH-1:0]        in_qos;
  logic [NUM_CH*TYPE_W-1:0] in_type;
  logic [NUM_CH*ID_W-1:0]   in_src;
  logic [NUM_CH*ID_W-1:0]   in_tgt;
  logic [NUM_CH*FLIT_W-1:0] in_data;
  logic [NUM_CH-1:0]        in_rdy;

  logic                     out_vld;
  logic                     out_qos;
  logic [TYPE_W-1:0]        out_type;
  logic [ID_W-1:0]          out_src;
  logic [ID_W-1:0]          out_tgt;
  logic [FLIT_W-1:0]        out_data;
  logic [CH_W-1:0]          out_ch;
  logic                     out_rdy;

  modport master (
    output in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
    input  in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data, out_ch
  );

  modport slave (
    input  in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
    output in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data, out_ch
  );
endinterface

// File: rtl/maze_pkt_ingress_fifo.sv
// maze_pkt_fifo: synchronous FIFO with combinational head read.
//   push/wdata : write when push and not full
//   pop/rdata  : rdata shows the head; pop advances when not empty
//   empty/full : registered-pointer status, no same-cycle bypass
module maze_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push && !full) wptr_d = wptr_q + PTR_ONE;
    if (pop && !empty) rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wptr_q[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/maze_pkt_ingress.sv
// maze_pkt_ingress: merges NUM_CH vld/rdy packet channels into one registered
// stream. Each channel owns a high and a low QoS FIFO; a round-robin arbiter
// serves the high class first, but after STARVE_MAX consecutive high grants
// with low traffic waiting, it forces one low grant.
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : in_* packed input channels with in_rdy backpressure,
//                out_* registered merged packet with out_ch source channel
module maze_pkt_ingress
  import maze_ingress_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DEPTH      = 4,
  parameter int TYPE_W     = 2,
  parameter int ID_W       = 6,
  parameter int FLIT_W     = 8,
  parameter int STARVE_MAX = 8
) (
  input logic                clk,
  input logic                rst_n,
  maze_pkt_ingress_if.slave  io
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EW   = TYPE_W + 2 * ID_W + FLIT_W;
  localparam int NF   = 2 * NUM_CH;
  localparam logic [7:0] SMAX = 8'(STARVE_MAX);

  typedef struct packed {
    logic [TYPE_W-1:0] ptype;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
  } entry_t;

  // FIFO index 2*ch+qos
  logic [NF-1:0] push_v, pop_v, empty_v, full_v;
  entry_t        wdata_v [NUM_CH];
  logic [EW-1:0] rdata_v [NF];

  logic              out_vld_q, out_vld_d;
  logic              out_qos_q, out_qos_d;
  entry_t            out_pkt_q, out_pkt_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CH_W-1:0]   hi_ptr_q, hi_ptr_d, lo_ptr_q, lo_ptr_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;

  logic [NUM_CH-1:0] hi_req, lo_req, in_rdy_c;
  logic              any_hi, any_lo, load, grant_hi;
  logic [7:0]        hi_req8, lo_req8;
  logic [2:0]        hi_ptr8, lo_ptr8, hi_pick, lo_pick;
  logic [CH_W-1:0]   ptr_nxt;
  int                gnt_ch;
  entry_t            head;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wdata_v[c] = {io.in_type[c*TYPE_W +: TYPE_W], io.in_src[c*ID_W +: ID_W],
                         io.in_tgt[c*ID_W +: ID_W], io.in_data[c*FLIT_W +: FLIT_W]};
    for (genvar q = 0; q < 2; q++) begin : g_qos
      maze_pkt_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_v[2*c+q]),
        .wdata (wdata_v[c]),
        .pop   (pop_v[2*c+q]),
        .rdata (rdata_v[2*c+q]),
        .empty (empty_v[2*c+q]),
        .full  (full_v[2*c+q])
      );
    end
  end

  always_comb begin
    hi_req   = '0;
    lo_req   = '0;
    in_rdy_c = '0;
    push_v   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      hi_req[c]     = !empty_v[2*c+1];
      lo_req[c]     = !empty_v[2*c];
      // Ready depends on the offered class only, never on in_vld.
      in_rdy_c[c]   = io.in_qos[c] ? !full_v[2*c+1] : !full_v[2*c];
      push_v[2*c+1] = io.in_vld[c] & in_rdy_c[c] & io.in_qos[c];
      push_v[2*c]   = io.in_vld[c] & in_rdy_c[c] & !io.in_qos[c];
    end
    any_hi = |hi_req;
    any_lo = |lo_req;
    load   = (!out_vld_q || io.out_rdy) && (any_hi || any_lo);
    // Starvation only matters when low traffic is actually waiting.
    grant_hi = any_hi && ((starve_cnt_q < SMAX) || !any_lo);

    hi_req8 = '0;
    lo_req8 = '0;
    hi_ptr8 = '0;
    lo_ptr8 = '0;
    hi_req8[NUM_CH-1:0] = hi_req;
    lo_req8[NUM_CH-1:0] = lo_req;
    hi_ptr8[CH_W-1:0]   = hi_ptr_q;
    lo_ptr8[CH_W-1:0]   = lo_ptr_q;
    hi_pick = rr_pick(hi_req8, hi_ptr8);
    lo_pick = rr_pick(lo_req8, lo_ptr8);
    gnt_ch  = grant_hi ? int'(hi_pick) : int'(lo_pick);
    ptr_nxt = (gnt_ch >= NUM_CH - 1) ? '0 : CH_W'(gnt_ch + 1);

    pop_v = '0;
    head  = '0;
    for (int f = 0; f < NF; f++) begin
      if (f == 2 * gnt_ch + (grant_hi ? 1 : 0)) begin
        pop_v[f] = load;
        head     = rdata_v[f];
      end
    end

    out_vld_d    = out_vld_q;
    out_qos_d    = out_qos_q;
    out_pkt_d    = out_pkt_q;
    out_ch_d     = out_ch_q;
    hi_ptr_d     = hi_ptr_q;
    lo_ptr_d     = lo_ptr_q;
    starve_cnt_d = starve_cnt_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_qos_d = grant_hi;
      out_pkt_d = head;
      out_ch_d  = CH_W'(gnt_ch);
      if (grant_hi) begin
        hi_ptr_d = ptr_nxt;
        if (starve_cnt_q < SMAX) starve_cnt_d = starve_cnt_q + 8'd1;
      end else begin
        lo_ptr_d     = ptr_nxt;
        starve_cnt_d = '0;
      end
    end else if (io.out_rdy) begin
      out_vld_d = 1'b0;
    end
    if (!any_lo) starve_cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q    <= 1'b0;
      out_qos_q    <= 1'b0;
      out_pkt_q    <= '0;
      out_ch_q     <= '0;
      hi_ptr_q     <= '0;
      lo_ptr_q     <= '0;
      starve_cnt_q <= '0;
    end else begin
      out_vld_q    <= out_vld_d;
      out_qos_q    <= out_qos_d;
      out_pkt_q    <= out_pkt_d;
      out_ch_q     <= out_ch_d;
      hi_ptr_q     <= hi_ptr_d;
      lo_ptr_q     <= lo_ptr_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign io.in_rdy   = in_rdy_c;
  assign io.out_vld  = out_vld_q;
  assign io.out_qos  = out_qos_q;
  assign io.out_type = out_pkt_q.ptype;
  assign io.out_src  = out_pkt_q.src;
  assign io.out_tgt  = out_pkt_q.tgt;
  assign io.out_data = out_pkt_q.data;
  assign io.out_ch   = out_ch_q;
endmodule

// File: tb/tb_maze_pkt_ingress.sv
// tb_maze_pkt_ingress: directed scenarios plus randomized traffic, checked by a
// queue-based reference model and a scoreboard monitor.
module tb_maze_pkt_ingress;
  import maze_ingress_pkg::*;

  localparam int NUM_CH = 2, DEPTH = 4, TYPE_W = 2, ID_W = 6, FLIT_W = 8;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  maze_pkt_ingress_if #(.NUM_CH(NUM_CH), .TYPE_W(TYPE_W), .ID_W(ID_W), .FLIT_W(FLIT_W)) bus ();

  maze_pkt_ingress #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .TYPE_W(TYPE_W), .ID_W(ID_W),
                     .FLIT_W(FLIT_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus.slave)
  );

  typedef struct { int ch; int qos; pkt_entry_t p; } out_t;
  typedef struct { int ch; int qos; int data; int t; } log_t;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: one queue per (channel, qos), an output slot, and the
  // arbitration bookkeeping, advanced once per clock edge.
  pkt_entry_t mq [2*NUM_CH][$];
  out_t       exp_q [$];
  log_t       out_log [$];
  bit         m_ovld;
  int         m_hi_ptr, m_lo_ptr, m_starve;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc_n++;

  always @(posedge clk or negedge rst_n) begin : model
    bit rdy [NUM_CH];
    bit any_hi, any_lo, hi;
    int base, g;
    out_t o;
    pkt_entry_t np;
    if (!rst_n) begin
      for (int f = 0; f < 2*NUM_CH; f++) mq[f].delete();
      exp_q.delete();
      m_ovld = 0; m_hi_ptr = 0; m_lo_ptr = 0; m_starve = 0;
    end else begin
      any_hi = 0; any_lo = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        rdy[c] = mq[2*c + int'(bus.in_qos[c])].size() < DEPTH;
        if (mq[2*c+1].size() > 0) any_hi = 1;
        if (mq[2*c].size() > 0) any_lo = 1;
      end
      if ((!m_ovld || bus.out_rdy) && (any_hi || any_lo)) begin
        hi = any_hi && (m_starve < STARVE_MAX || !any_lo);
        base = hi ? m_hi_ptr : m_lo_ptr;
        g = -1;
        for (int k = 0; k < NUM_CH; k++)
          if (g < 0 && mq[2*((base+k)%NUM_CH) + int'(hi)].size() > 0) g = (base+k)%NUM_CH;
        o.ch = g; o.qos = int'(hi);
        o.p = mq[2*g + int'(hi)].pop_front();
        exp_q.push_back(o);
        m_ovld = 1;
        if (hi) begin
          m_hi_ptr = (g + 1) % NUM_CH;
          m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
        end else begin
          m_lo_ptr = (g + 1) % NUM_CH;
          m_starve = 0;
        end
      end else if (m_ovld && bus.out_rdy) begin
        m_ovld = 0;
      end
      if (!any_lo) m_starve = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.in_vld[c] && rdy[c]) begin
          np.ptype = bus.in_type[c*TYPE_W +: TYPE_W];
          np.src   = bus.in_src[c*ID_W +: ID_W];
          np.tgt   = bus.in_tgt[c*ID_W +: ID_W];
          np.data  = bus.in_data[c*FLIT_W +: FLIT_W];
          mq[2*c + int'(bus.in_qos[c])].push_back(np);
        end
      end
    end
  end

  // Monitor: compares on the falling edge, between driving and capture.
  always @(negedge clk) begin : monitor
    logic [NUM_CH-1:0] r;
    out_t e;
    log_t l;
    for (int c = 0; c < NUM_CH; c++)
      r[c] = mq[2*c + int'(bus.in_qos[c])].size() < DEPTH;
    chk("in_rdy", 32'(bus.in_rdy), 32'(r));
    chk("out_vld", 32'(bus.out_vld), 32'(m_ovld));
    if (bus.out_vld && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        chk("sb_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pkt",
            32'({bus.out_ch, bus.out_qos, bus.out_type, bus.out_src, bus.out_tgt, bus.out_data}),
            32'({1'(e.ch), 1'(e.qos), e.p.ptype, e.p.src, e.p.tgt, e.p.data}));
      end
      l.ch = int'(bus.out_ch); l.qos = int'(bus.out_qos);
      l.data = int'(bus.out_data); l.t = cyc_n;
      out_log.push_back(l);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int c, input bit v, input bit q, input logic [1:0] ty,
                       input logic [5:0] s, input logic [5:0] t, input logic [7:0] d);
    bus.in_vld[c] = v;
    bus.in_qos[c] = q;
    bus.in_type[c*TYPE_W +: TYPE_W] = ty;
    bus.in_src[c*ID_W +: ID_W]      = s;
    bus.in_tgt[c*ID_W +: ID_W]      = t;
    bus.in_data[c*FLIT_W +: FLIT_W] = d;
  endtask

  task automatic idle_all();
    for (int c = 0; c < NUM_CH; c++) drive(c, 0, 0, 2'd0, 6'd0, 6'd0, 8'd0);
  endtask

  initial begin
    int m;
    bit acc;
    int hi_exp [$];
    int lo_exp [$];
    int hi_got [$];
    int lo_got [$];

    bus.in_vld = '0; bus.in_qos = '0; bus.in_type = '0; bus.in_src = '0;
    bus.in_tgt = '0; bus.in_data = '0; bus.out_rdy = 1'b0;

    // Reset state
    repeat (2) cyc();
    chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
    chk("rst_in_rdy", 32'(bus.in_rdy), 32'h3);
    chk("rst_fields", 32'({bus.out_qos, bus.out_type, bus.out_src, bus.out_tgt, bus.out_data}), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_rdy", 32'(bus.in_rdy), 32'h3);

    // Latency: accept at edge k, visible after edge k+1
    bus.out_rdy = 1'b1;
    drive(0, 1, 1, 2'b00, 6'd5, 6'd12, 8'hA5);
    cyc();
    idle_all();
    chk("lat_not_early", 32'(bus.out_vld), 32'd0);
    cyc();
    chk("lat_vld", 32'(bus.out_vld), 32'd1);
    chk("lat_pkt", 32'({bus.out_ch, bus.out_qos, bus.out_type, bus.out_src, bus.out_tgt, bus.out_data}),
        32'({1'b0, 1'b1, 2'b00, 6'd5, 6'd12, 8'hA5}));
    repeat (3) cyc();

    // Backpressure: 4 in FIFO + 1 in output register, then ready drops
    bus.out_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1, 1, 0, 2'b01, 6'd1, 6'd2, 8'(i));
      chk("bp_rdy_accept", 32'(bus.in_rdy[1]), 32'd1);
      cyc();
    end
    drive(1, 1, 0, 2'b01, 6'd1, 6'd2, 8'd6);
    chk("bp_full", 32'(bus.in_rdy[1]), 32'd0);
    cyc();
    chk("bp_full_hold", 32'(bus.in_rdy[1]), 32'd0);
    chk("bp_out_stable", 32'(bus.out_data), 32'd1);
    idle_all();
    out_log.delete();
    bus.out_rdy = 1'b1;
    cyc();
    chk("bp_rdy_back", 32'(bus.in_rdy[1]), 32'd1);
    repeat (8) cyc();
    chk("bp_count", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < out_log.size() && i < 5; i++)
      chk("bp_order", 32'(out_log[i].data), 32'(i + 1));

    // Round-robin between two continuously busy high channels
    out_log.delete();
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 1, 2'b00, 6'd3, 6'd4, 8'(i));
      drive(1, 1, 1, 2'b00, 6'd7, 6'd8, 8'(8'h40 + i));
      cyc();
    end
    idle_all();
    repeat (14) cyc();
    chk("rr_count_min", 32'(out_log.size() >= 10), 32'd1);
    for (int i = 1; i < 10 && i < out_log.size(); i++) begin
      chk("rr_alt", 32'(out_log[i].ch), 32'((out_log[0].ch + i) % 2));
      chk("rr_rate", 32'(out_log[i].t - out_log[i-1].t), 32'd1);
    end

    // Starvation: ch0 high stream, lone low packet on ch1
    drive(0, 1, 1, 2'b11, 6'd9, 6'd9, 8'h11);
    repeat (6) cyc();
    for (int rep = 0; rep < 2; rep++) begin
      drive(1, 1, 0, 2'b10, 6'd3, 6'd4, 8'(8'h70 + rep));
      cyc();
      drive(1, 0, 0, 2'b00, 6'd0, 6'd0, 8'd0);
      m = 0;
      do begin
        cyc();
        m++;
      end while (!(bus.out_vld && !bus.out_qos) && m < 20);
      chk("starve_wait", 32'(m), 32'd4);
      chk("starve_pkt", 32'({bus.out_ch, bus.out_data}), 32'({1'b1, 8'(8'h70 + rep)}));
      cyc();
      chk("starve_resume", 32'(bus.out_qos), 32'd1);
      repeat (3) cyc();
    end
    idle_all();
    repeat (10) cyc();

    // Reset mid-stream with packets buffered
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 2'b01, 6'd2, 6'd3, 8'(8'hC0 + i));
      cyc();
    end
    idle_all();
    cyc();
    chk("mid_pre_vld", 32'(bus.out_vld), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_async_vld", 32'(bus.out_vld), 32'd0);
    chk("mid_async_rdy", 32'(bus.in_rdy), 32'h3);
    chk("mid_async_data", 32'(bus.out_data), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("mid_no_stale", 32'(bus.out_vld), 32'd0);
    end

    // Per-class ordering on one channel under random backpressure
    out_log.delete();
    for (int i = 1; i <= 8; i++) begin
      drive(0, 1, 1'(i % 2), 2'b00, 6'd1, 6'd1, 8'(i));
      if (i % 2) hi_exp.push_back(i); else lo_exp.push_back(i);
      m = 0;
      do begin
        acc = bus.in_rdy[0];
        bus.out_rdy = 1'($urandom_range(0, 1));
        cyc();
        m++;
      end while (!acc && m < 50);
      chk("ord_accept", 32'(acc), 32'd1);
    end
    idle_all();
    bus.out_rdy = 1'b1;
    repeat (14) cyc();
    foreach (out_log[i]) begin
      if (out_log[i].qos == 1) hi_got.push_back(out_log[i].data);
      else lo_got.push_back(out_log[i].data);
    end
    chk("ord_hi_cnt", 32'(hi_got.size()), 32'd4);
    chk("ord_lo_cnt", 32'(lo_got.size()), 32'd4);
    for (int i = 0; i < 4 && i < hi_got.size(); i++) chk("ord_hi", 32'(hi_got[i]), 32'(hi_exp[i]));
    for (int i = 0; i < 4 && i < lo_got.size(); i++) chk("ord_lo", 32'(lo_got[i]), 32'(lo_exp[i]));

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < NUM_CH; c++)
        drive(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom),
              6'($urandom), 6'($urandom), 8'($urandom));
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle_all();
    bus.out_rdy = 1'b1;
    repeat (30) cyc();
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_out_vld", 32'(bus.out_vld), 32'd0);
    chk("drain_in_rdy", 32'(bus.in_rdy), 32'h3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/maze_pkt_ingress.md
# maze_pkt_ingress

Parametrised successor to the single-channel packet input port. It accepts `NUM_CH` independent packet input channels, each using the same vld/rdy packet fields (qos, type, src, tgt, data). Every channel feeds a pair of per-QoS FIFOs. A QoS-aware round-robin arbiter with low-priority starvation protection merges all of them into one registered packet stream toward the MAZE node router.

## Interface
- `NUM_CH`, 2: number of input channels (1–8)
- `DEPTH`, 4: entries per FIFO, power of 2, ≥2
- `TYPE_W`, 2: packet type width (00 unicast, 01 X-multicast, 10 Y-multicast, 11 broadcast)
- `ID_W`, 6: node ID width
- `FLIT_W`, 8: data payload width
- `STARVE_MAX`, 8: consecutive high-priority grants allowed while low-priority traffic waits (1–255)

Ports:
- `clk` in 1: single clock, all state on the rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_vld` in NUM_CH: per-channel packet valid
- `in_qos` in NUM_CH: per-channel QoS (1 = high)
- `in_type` in NUM_CH*TYPE_W: packed, channel i at [i*TYPE_W +: TYPE_W]; src, tgt and data are packed the same way
- `in_src` in NUM_CH*ID_W: source IDs
- `in_tgt` in NUM_CH*ID_W: target IDs
- `in_data` in NUM_CH*FLIT_W: payloads
- `in_rdy` out NUM_CH: per-channel ready (backpressure)
- `out_vld` out 1: merged packet valid
- `out_qos` out 1; `out_type` out TYPE_W; `out_src` out ID_W; `out_tgt` out ID_W; `out_data` out FLIT_W: merged packet fields
- `out_rdy` in 1: downstream ready
- `out_ch` out $clog2(NUM_CH) (min 1): channel the current output packet came from

## Operation
- **FIFOs.** There are 2·NUM_CH FIFOs, one per (channel, qos). Each entry holds {type, src, tgt, data}; qos is implied by the FIFO.
- **Input handshake.**
  - `in_rdy[i] = !full(FIFO[i][in_qos[i]])`. It is combinational on `in_qos` and FIFO state only, never on `in_vld`.
  - A write happens when `in_vld[i] & in_rdy[i]`.
- **Output register.** A single output register holds the current packet.
  - It loads when it is empty or when `out_vld & out_rdy` in the same cycle, and a candidate exists.
  - The chosen FIFO pops on that same edge. Back-to-back throughput is one packet per cycle.
- **Arbitration** runs at each load opportunity:
  - **High class.** If any high FIFO is non-empty and `starve_cnt < STARVE_MAX`, grant the high class. Round-robin starts at `hi_ptr`; after the grant, `hi_ptr` = granted+1 mod NUM_CH.
  - **Low class.** Otherwise, if any low FIFO is non-empty, grant the low class. Round-robin starts at `lo_ptr`, which updates the same way.
  - **Starvation counter.**
    - Increments on a high grant while any low FIFO is non-empty, saturating at STARVE_MAX.
    - Clears to 0 on any low grant.
    - Clears to 0 in any cycle where no low FIFO is non-empty.
- **Ordering.** Packets are never reordered within one (channel, qos). No ordering is guaranteed across QoS classes or across channels.
- **Fields.** Packets pass through unmodified. No type/ID checking is done here.

## Timing
- **Reset values:** `out_vld`=0; all out fields 0; `out_ch`=0; both pointers 0; `starve_cnt`=0; all FIFOs empty.
  - `in_rdy` is all-ones during and after reset, because the FIFOs are empty.
- **Latency.** A packet accepted at edge k can be presented with `out_vld`=1 in the cycle after edge k+1 at the earliest (2 cycles). There is no bypass path.
- **Output stability.** While `out_vld & !out_rdy`, all out fields and `out_ch` hold stable.
- **Full boundary.**
  - A FIFO at DEPTH entries drives `in_rdy` low.
  - If that FIFO is popped at edge k, `in_rdy` rises in cycle k+1. There is no same-cycle pop-to-ready path.
- **Empty boundary.** Write and pop cannot coincide on an empty FIFO, since a pop requires an entry visible before the edge.
- **Simultaneous push and pop** on a non-empty FIFO leaves the count unchanged.
- **Pointer wrap.** Read/write pointers use $clog2(DEPTH)+1 bits and wrap naturally. Full is detected when the MSBs differ and the LSBs are equal.
- **Reset mid-operation.** Asynchronous assertion immediately clears `out_vld` and discards all buffered packets. No partial state survives.

## Structure
- **Package `maze_ingress_pkg`:**
  - packed struct `pkt_entry_t` {type, src, tgt, data}, parametrised via package parameters that default to the `TYPE_W`/`ID_W`/`FLIT_W` defaults
  - function `rr_pick(req, ptr)` returning the first set bit at or after `ptr`, with wrap
- **Sub-module `maze_pkt_fifo`:** (DEPTH, WIDTH)
  - ports: clk, rst_n, push, wdata, pop, rdata, empty, full
  - rdata shows the head combinationally
  - instantiated 2·NUM_CH times through a generate loop

## Test plan
- **Latency.** NUM_CH=2, single packet on ch0 (qos=1, type=00, src=5, tgt=12, data=0xA5) with `out_rdy`=1 → `out_vld` exactly 2 cycles after accept, with identical fields, `out_ch`=0, `out_qos`=1.
- **Backpressure.** Hold `out_rdy`=0 and push 5 low packets on ch1 with DEPTH=4 → 4 FIFO entries plus 1 in the output register are accepted, then `in_rdy[1]`=0. Release `out_rdy` → 5 packets out in order, `in_rdy[1]` back to 1.
- **Round-robin.** Both channels continuously push high traffic → `out_ch` alternates 0,1,0,1 with one packet per cycle.
- **Starvation.** STARVE_MAX=3, ch0 continuous high traffic, one low packet on ch1 → 3 high grants, then the low packet, then high traffic resumes; `starve_cnt` returns to 0.
- **Reset mid-stream.** Pulse `rst_n` low mid-stream with 3 packets buffered → `out_vld` drops asynchronously, and no stale packet appears after release.
- **Per-class ordering.** Interleave qos 0/1 on one channel with data 1..8 → within each class the output data order matches the input order.
